// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decode->execute immediate sign/zero-extend stage; `IMM_UPPER_EN adds LUI upper-immediate.
// Latency: a beat pushed into an empty buffer appears at out_* one clock later.
// Backpressure: 2-entry buffer; in_ready comes from registered count only, never combinationally from out_ready.

module imm_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_rdy = (r_count != CNT_W'(DEPTH));
  assign pop_vld  = (r_count != '0);
  assign pop_dat  = r_mem[r_rd_ptr];
  // A beat offered during flush is dropped; a pop during flush still completes.
  assign w_push   = push_vld && push_rdy && !flush;
  assign w_pop    = pop_vld && pop_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_dat;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

module imm_extend_pipe #(
  parameter int          DATA_W       = 32,
  parameter int          IMM_W        = 16,
  parameter int          SHAMT_W      = 5,
  parameter logic [5:0]  SHIFT_OPCODE = 6'b000010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [IMM_W-1:0]  instr,
  input  logic              zext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_shift
);

  localparam logic [5:0] LUI_OPCODE = 6'b001111;

  typedef struct packed {
    logic              shift;
    logic [DATA_W-1:0] imm;
  } imm_ent_t;

  logic [SHAMT_W-1:0] w_shamt;
  imm_ent_t           w_new;
  imm_ent_t           w_head;

  assign w_shamt = instr[IMM_W-1 -: SHAMT_W];

  always_comb begin
    w_new = '0;
    if (opcode == SHIFT_OPCODE) begin
      w_new.shift = 1'b1;
      w_new.imm   = DATA_W'($signed(w_shamt));
`ifdef IMM_UPPER_EN
    end else if (opcode == LUI_OPCODE) begin
      w_new.imm   = DATA_W'(instr) << (DATA_W - IMM_W);
`endif
    end else if (zext) begin
      w_new.imm   = DATA_W'(instr);
    end else begin
      w_new.imm   = DATA_W'($signed(instr));
    end
  end

  imm_fifo #(
    .W     ($bits(imm_ent_t)),
    .DEPTH (2)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (w_new),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (w_head)
  );

  assign out_imm   = out_valid ? w_head.imm   : '0;
  assign out_shift = out_valid ? w_head.shift : 1'b0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized bench for imm_extend_pipe with a queue-based reference model; define IMM_UPPER_EN to test the LUI build.
module tb_imm_extend_pipe;

`ifdef IMM_UPPER_EN
  localparam bit UPPER = 1'b1;
`else
  localparam bit UPPER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [15:0] instr;
  logic        zext;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic        out_shift;

  typedef struct {
    logic [31:0] imm;
    logic        sh;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  imm_extend_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .instr     (instr),
    .zext      (zext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_shift (out_shift)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference extension computed with integer arithmetic on the field values.
  function automatic logic [31:0] ref_imm(input logic [5:0] op, input logic [15:0] ins, input logic z);
    longint v;
    if (op == 6'd2) begin
      v = longint'(ins) / 2048;
      if (v >= 16) v = v - 32;
    end else if (UPPER && op == 6'd15) begin
      v = longint'(ins) * 65536;
    end else if (z) begin
      v = longint'(ins);
    end else begin
      v = longint'(ins);
      if (v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_imm", 64'(out_imm), 64'((q.size() != 0) ? q[0].imm : 32'h0));
    chk("out_shift", 64'(out_shift), 64'((q.size() != 0) ? q[0].sh : 1'b0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
  endtask

  // Called at a negedge: check, drive, advance model to the coming posedge, wait.
  task automatic step(input logic v, input logic [5:0] op, input logic [15:0] ins,
                      input logic z, input logic ordy, input logic fl);
    bit   do_push;
    bit   do_pop;
    ent_t e;
    check_outputs();
    in_valid  = v;
    opcode    = op;
    instr     = ins;
    zext      = z;
    out_ready = ordy;
    flush     = fl;
    do_push = v && (q.size() < 2);
    do_pop  = (q.size() != 0) && ordy;
    if (do_pop) void'(q.pop_front());
    if (fl) begin
      q.delete();
    end else if (do_push) begin
      e.imm = ref_imm(op, ins, z);
      e.sh  = (op == 6'd2);
      q.push_back(e);
    end
    assert (q.size() <= 2) else $error("model overflow");
    @(negedge clk);
  endtask

  task automatic rand_cycles(input int n);
    logic [5:0] op;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(3))
        0:       op = 6'd2;
        1:       op = 6'd15;
        2:       op = 6'd8;
        default: op = 6'($urandom);
      endcase
      step(1'($urandom), op, 16'($urandom), 1'($urandom),
           $urandom_range(9) < 7, $urandom_range(19) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; opcode = 6'd8;
    instr = 16'h1234; zext = 1'b0; out_ready = 1'b1;
    // Reset held with a valid beat offered: nothing enters.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_imm", 64'(out_imm), 64'h0);
      chk("rst_out_shift", 64'(out_shift), 64'h0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);

    // Shift-amount extraction.
    step(1, 6'd2, 16'hF800, 0, 1, 0);
    chk("shift_neg_imm", 64'(out_imm), 64'hFFFF_FFFF);
    chk("shift_neg_flag", 64'(out_shift), 64'h1);
    step(1, 6'd2, 16'h7800, 1, 1, 0);
    chk("shift_pos_imm", 64'(out_imm), 64'h0000_000F);

    // Sign vs zero extension.
    step(1, 6'd8, 16'h8001, 0, 1, 0);
    chk("sext_imm", 64'(out_imm), 64'hFFFF_8001);
    step(1, 6'd8, 16'h8001, 1, 1, 0);
    chk("zext_imm", 64'(out_imm), 64'h0000_8001);
    chk("zext_flag", 64'(out_shift), 64'h0);
    step(0, 6'd0, 16'h0, 0, 1, 0);

    // Back-pressure: fill, hold head, third push ignored, drain in order.
    step(1, 6'd8, 16'h0001, 0, 0, 0);
    step(1, 6'd8, 16'h0002, 0, 0, 0);
    chk("full_in_ready", 64'(in_ready), 64'h0);
    chk("hold_imm", 64'(out_imm), 64'h1);
    step(1, 6'd8, 16'h0003, 0, 0, 0);
    chk("hold_imm2", 64'(out_imm), 64'h1);
    step(0, 6'd0, 16'h0, 0, 1, 0);
    chk("drain_b", 64'(out_imm), 64'h2);
    chk("ready_after_pop", 64'(in_ready), 64'h1);
    step(0, 6'd0, 16'h0, 0, 1, 0);
    chk("drain_empty", 64'(out_valid), 64'h0);

    // Flush with a full buffer and a beat offered.
    step(1, 6'd8, 16'h0011, 0, 0, 0);
    step(1, 6'd8, 16'h0022, 0, 0, 0);
    step(1, 6'd8, 16'h0033, 0, 0, 1);
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_ready", 64'(in_ready), 64'h1);
    step(0, 6'd0, 16'h0, 0, 1, 0);
    chk("flush_beat_gone", 64'(out_valid), 64'h0);

    // LUI opcode in either build.
    step(1, 6'd15, 16'h1234, 1, 1, 0);
    chk("lui_imm", 64'(out_imm), UPPER ? 64'h1234_0000 : 64'h0000_1234);
    step(0, 6'd0, 16'h0, 0, 1, 0);

    rand_cycles(400);

    // Asynchronous reset mid-operation with entries held.
    step(1, 6'd8, 16'hAAAA, 0, 0, 0);
    step(1, 6'd8, 16'h5555, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_imm", 64'(out_imm), 64'h0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rand_cycles(400);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
